// File: rtl/osr_param.sv
// osr_param: parametrised PIO output shift register with FIFO handshake and autopull (optional OSR_PULL_IFEMPTY_EN)
module osr_param #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mov_data,
  input  logic              mov_en,
  input  logic              pull_req,
  input  logic              pull_block,
`ifdef OSR_PULL_IFEMPTY_EN
  input  logic              pull_ifempty,
`endif
  input  logic              out_req,
  input  logic [CNT_W-1:0]  out_count,
  input  logic              shiftdir,
  input  logic              autopull,
  input  logic [CNT_W-1:0]  pull_thresh,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_valid,
  output logic              fifo_pop,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              stall,
  output logic              instr_done,
  output logic [CNT_W:0]    shift_cnt
);
  localparam logic [CNT_W:0]   FULL_W = (CNT_W+1)'(DATA_W);
  localparam logic [CNT_W+1:0] SUM_W  = (CNT_W+2)'(DATA_W);
  logic [DATA_W-1:0] osr_q, osr_d, data_out_q, data_out_d;
  logic [CNT_W:0]    cnt_q, cnt_d, thr, n, cnt_sat;
  logic [CNT_W+1:0]  sum;
  logic              out_valid_q, out_exec;
  assign thr       = (pull_thresh == '0) ? FULL_W : {1'b0, pull_thresh};
  assign n         = (out_count == '0) ? FULL_W : {1'b0, out_count};
  assign sum       = {1'b0, cnt_q} + {1'b0, n};
  assign cnt_sat   = (sum > SUM_W) ? FULL_W : sum[CNT_W:0];
  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign shift_cnt = cnt_q;
  // Request decode by priority, OUT shifting and autopull refill on non-MOV/PULL cycles
  always_comb begin
    osr_d      = osr_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    out_exec   = 1'b0;
    stall      = 1'b0;
    fifo_pop   = 1'b0;
    instr_done = 1'b0;
    if (!rst) begin
      if (mov_en) begin
        osr_d      = mov_data;
        cnt_d      = '0;
        instr_done = 1'b1;
      end else if (pull_req) begin
`ifdef OSR_PULL_IFEMPTY_EN
        if (pull_ifempty && cnt_q < thr) instr_done = 1'b1; else
`endif
        if (fifo_valid) begin
          osr_d      = fifo_data;
          cnt_d      = '0;
          fifo_pop   = 1'b1;
          instr_done = 1'b1;
        end else if (pull_block) begin
          stall = 1'b1;
        end else begin
          osr_d      = mov_data;
          cnt_d      = '0;
          instr_done = 1'b1;
        end
      end else begin
        if (out_req) begin
          if (autopull && cnt_q >= thr) begin
            stall = 1'b1;
          end else begin
            out_exec   = 1'b1;
            instr_done = 1'b1;
            cnt_d      = cnt_sat;
            data_out_d = shiftdir ? (osr_q & ~({DATA_W{1'b1}} << n)) : (osr_q >> (FULL_W - n));
            osr_d      = shiftdir ? (osr_q >> n) : (osr_q << n);
          end
        end
        if (autopull && fifo_valid && cnt_d >= thr) begin
          osr_d    = fifo_data;
          cnt_d    = '0;
          fifo_pop = 1'b1;
        end
      end
    end
  end
  // Register the shifter state and output word
  always_ff @(posedge clk) begin
    if (rst) begin
      osr_q       <= '0;
      cnt_q       <= FULL_W;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      osr_q       <= osr_d;
      cnt_q       <= cnt_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_exec;
    end
  end
endmodule
